// File: rtl/gpmc_wb_bridge.sv
// GPMC async muxed AD -> single Wishbone cycle bridge (16-bit, non-burst).
// Optional ack timeout: define GPMC_WB_TIMEOUT_EN.
module gpmc_wb_bridge #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gpmc_csn,
  input  logic                  gpmc_advn,
  input  logic                  gpmc_wen,
  input  logic                  gpmc_oen,
  input  logic [15:0]           gpmc_ad_in,
  output logic [15:0]           gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_write,
  output logic                  wbm_cycle,
  input  logic                  wbm_ack
);

  typedef enum logic [2:0] {
    IDLE,
    WR_CYC,
    RD_CYC,
    RD_DRIVE,
    WAIT_END
  } state_t;

  localparam logic [15:0] TMO_DATA = 16'hDEAD;

  state_t state, state_nx;

  // strobe order: {csn, advn, wen, oen}; csn needs no edge copy
  logic [3:0] s1, s2;
  logic [2:0] s3;

  logic csn_s, wen_s, oen_s;
  logic adv_rise, wen_fall, oen_fall;
  logic start_wr, start_rd, cyc_end, tmo;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      s1 <= {gpmc_csn, gpmc_advn,
             gpmc_wen, gpmc_oen};
      s2 <= s1;
      s3 <= s2[2:0];
    end
  end

  assign csn_s    = s2[3];
  assign wen_s    = s2[1];
  assign oen_s    = s2[0];
  assign adv_rise = s2[2] & ~s3[2];
  assign wen_fall = ~s2[1] & s3[1];
  assign oen_fall = ~s2[0] & s3[0];

  assign start_wr = (state == IDLE)
                  & wen_fall & ~csn_s;
  assign start_rd = (state == IDLE)
                  & oen_fall & ~wen_fall
                  & ~csn_s;
  assign cyc_end  = wbm_ack | tmo;

`ifdef GPMC_WB_TIMEOUT_EN
  localparam int CW =
    $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  assign tmo = wbm_cycle &
    (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= '0;
    else if (start_wr || start_rd)
      cnt <= '0;
    else if (wbm_cycle && !tmo)
      cnt <= cnt + CW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_wr)
          state_nx = WR_CYC;
        else if (start_rd)
          state_nx = RD_CYC;
      end
      WR_CYC: begin
        if (cyc_end)
          state_nx = csn_s ? IDLE
                           : WAIT_END;
      end
      RD_CYC: begin
        if (cyc_end)
          state_nx = csn_s ? IDLE
                           : RD_DRIVE;
      end
      RD_DRIVE: begin
        if (oen_s || csn_s)
          state_nx = IDLE;
      end
      WAIT_END: begin
        if (wen_s || csn_s)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wbm_cycle  = 1'b0;
    wbm_write  = 1'b0;
    gpmc_ad_oe = 1'b0;
    case (state)
      WR_CYC: begin
        wbm_cycle = 1'b1;
        wbm_write = 1'b1;
      end
      RD_CYC:   wbm_cycle  = 1'b1;
      RD_DRIVE: gpmc_ad_oe = 1'b1;
      default: ;
    endcase
  end

  // AD is only sampled on synced strobe edges
  always_ff @(posedge clk) begin
    if (!reset) begin
      wbm_address   <= '0;
      wbm_writedata <= '0;
      gpmc_ad_out   <= '0;
    end else begin
      if (adv_rise && !csn_s)
        wbm_address <=
          gpmc_ad_in[ADDR_WIDTH-1:0];
      if (start_wr)
        wbm_writedata <= gpmc_ad_in;
      if (state == RD_CYC && cyc_end
          && !csn_s)
        gpmc_ad_out <= wbm_ack
          ? wbm_readdata : TMO_DATA;
    end
  end

endmodule
